// File: rtl/serial_ripple_subtractor.sv
// rtl/serial_ripple_subtractor.sv - bit-serial a - b - bin, one bit per clock, LSB first
// Optional SERIAL_SUB_SAT_EN: floor the result at zero when the final borrow is set.
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;

    logic             accept;
    logic             last_bit;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_full;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign d_bit    = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next  = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & br) | (b_sr[0] & br);
    assign res_full = {d_bit, res_sr[WIDTH-1:1]};

    // Both flags decode straight from the state register, so outputs stay registered.
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            br     <= bin;
        end else if (state == SHIFT) begin
            cnt    <= cnt + CW'(1);
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_full;
            br     <= br_next;
            // The last bit is still in flight, so publish the assembled word, not res_sr.
            if (last_bit) begin
`ifdef SERIAL_SUB_SAT_EN
                diff <= br_next ? '0 : res_full;
`else
                diff <= res_full;
`endif
                bout <= br_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb/tb_serial_ripple_subtractor.sv - randomized and directed checks of serial_ripple_subtractor
module tb_serial_ripple_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int n_checks;
    int n_fails;

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer subtraction, borrow is "went negative".
    function automatic void ref_sub(input int av, input int bv, input int binv,
                                    output int d, output int bo);
        int r;
        r  = av - bv - binv;
        bo = (r < 0) ? 1 : 0;
        d  = r & ((1 << W) - 1);
`ifdef SERIAL_SUB_SAT_EN
        if (bo == 1) d = 0;
`endif
    endfunction

    // Issues one request from idle (called at a negedge) and checks result and timing.
    task automatic run_op(input int av, input int bv, input int binv, input string tag);
        int busy_cycles;
        int n;
        int ed;
        int eb;
        ref_sub(av, bv, binv, ed, eb);
        start = 1'b1;
        a     = W'(av);
        b     = W'(bv);
        bin   = binv[0];
        @(negedge clk);
        start = 1'b0;
        busy_cycles = 0;
        n = 0;
        while (!done && n < 20) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_diff"}, 32'(diff), 32'(ed));
        check_eq({tag, "_bout"}, 32'(bout), 32'(eb));
        check_eq({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(W));
    endtask

    task automatic expect_no_done(input int cycles, input string tag);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_eq(tag, 32'(pulses), 32'd0);
    endtask

    initial begin
        int ed;
        int eb;
        int n;
        int ca;
        int cb;
        int cbin;

        n_checks = 0;
        n_fails  = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_outputs", {28'd0, busy, done, bout, 1'b0} | 32'(diff), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(9, 3, 0, "sub_9_3");
        run_op(3, 9, 0, "sub_3_9");
        run_op(15, 15, 0, "sub_f_f");
        run_op(0, 0, 1, "sub_0_0_b");

        // Second start during busy must be ignored.
        start = 1'b1;
        a     = 4'd7;
        b     = 4'd2;
        bin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a     = 4'd1;
        b     = 4'd1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("ignore_done", 32'(done), 32'd1);
        check_eq("ignore_diff", 32'(diff), 32'd5);
        check_eq("ignore_bout", 32'(bout), 32'd0);
        expect_no_done(8, "ignore_no_second_done");

        // Prime a nonzero borrow, then reset at bit 2 of a new operation.
        run_op(0, 0, 1, "pre_reset");
        start = 1'b1;
        a     = 4'd12;
        b     = 4'd5;
        bin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midreset_outputs", {28'd0, busy, done, bout, 1'b0} | 32'(diff), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_no_done(8, "midreset_no_done");
        run_op(5, 5, 0, "post_reset_5_5");

        // Exhaustive back-to-back, each new start issued in the done cycle.
        ca   = 0;
        cb   = 0;
        cbin = 0;
        start = 1'b1;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        for (int i = 0; i < 512; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == 1) start = 1'b0;
            end while (!done && n < 20);
            ref_sub(ca, cb, cbin, ed, eb);
            check_eq($sformatf("exh_diff_%0d_%0d_%0d", ca, cb, cbin), 32'(diff), 32'(ed));
            check_eq($sformatf("exh_bout_%0d_%0d_%0d", ca, cb, cbin), 32'(bout), 32'(eb));
            check_eq($sformatf("exh_period_%0d", i), 32'(n), 32'(W + 1));
            if (i < 511) begin
                ca    = ((i + 1) >> 5) & 15;
                cb    = ((i + 1) >> 1) & 15;
                cbin  = (i + 1) & 1;
                start = 1'b1;
                a     = W'(ca);
                b     = W'(cb);
                bin   = cbin[0];
            end
        end
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 1)), $sformatf("rand_%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/serial_ripple_subtractor.md
# serial_ripple_subtractor

Bit-serial subtractor computing `a - b - bin` over `WIDTH` cycles. It resolves one bit per clock, LSB first, through a single registered borrow stage. It is the subtracting counterpart of the team's combinational ripple adders. It sits in area-constrained datapaths where a full-width combinational borrow chain is not wanted, and it uses a start/busy/done handshake.

## Interface
Parameters:
- `WIDTH`, default 4: operand and result width; legal range 2..32.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request; sampled only when `busy`=0.
- `a` in WIDTH: minuend; sampled on the accepting edge.
- `b` in WIDTH: subtrahend; sampled on the accepting edge.
- `bin` in 1: borrow in; sampled on the accepting edge.
- `busy` out 1: high while bits are being processed.
- `done` out 1: one-cycle pulse when the result is written.
- `diff` out WIDTH: registered result; holds its value until the next completion.
- `bout` out 1: registered final borrow out.

## Operation
- States: IDLE, SHIFT, DONE. Bit counter is `$clog2(WIDTH)` bits wide.
- IDLE or DONE with `start`=1:
  - latch `a`, `b` and `bin` into shift and borrow registers;
  - clear the counter; go to SHIFT.
- DONE with `start`=0: go to IDLE.
- SHIFT, each edge processes bit k = counter:
  - `d_k = a_k ^ b_k ^ br`
  - `br' = (~a_k & b_k) | (~a_k & br) | (b_k & br)`
  - shift `d_k` into the result shift register at MSB; shift operands right.
  - Counter increments.
- SHIFT, edge with counter = WIDTH-1:
  - write the assembled result to `diff` and the final `br'` to `bout`;
  - go to DONE.
- `start` while `busy`=1 is ignored. The operands in flight are unaffected.
- `diff` and `bout` change only on completion. During SHIFT they hold the previous result.
- Arithmetic: result is `(a - b - bin) mod 2^WIDTH`. `bout`=1 exactly when `a < b + bin` as unsigned values.
- Reset, including mid-operation:
  - state IDLE; `busy`=0, `done`=0, `diff`=0, `bout`=0;
  - counter, shift registers and borrow register cleared;
  - the in-flight operation is discarded and no `done` is produced.

## Timing
- Accepting edge E0 (`start`=1, `busy`=0) → `busy`=1 in the cycle after E0.
- Edges E1..E(WIDTH) process bits 0..WIDTH-1.
- After E(WIDTH): `busy`=0, `done`=1, `diff` and `bout` valid.
- Latency from accepting edge to `done` visible is WIDTH edges (4 for the default).
- `done` is high for exactly one cycle.
- Back-to-back: `start`=1 during the `done` cycle is accepted at E(WIDTH+1). `busy` rises and `done` falls in the same cycle. Throughput is one result per WIDTH+1 cycles.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Configuration
- `SERIAL_SUB_SAT_EN` defined: on completion with final borrow = 1, `diff` is forced to 0 (unsigned floor saturation). `bout` still reports 1.
- `SERIAL_SUB_SAT_EN` undefined: `diff` wraps modulo 2^WIDTH.
- Timing and handshake are identical in both builds.

## Test plan
- WIDTH=4, a=9, b=3, bin=0 → after 4 edges: `done`=1, `diff`=6, `bout`=0; `busy` high for exactly 4 cycles.
- a=3, b=9, bin=0 → `diff`=0xA, `bout`=1. With `SERIAL_SUB_SAT_EN`: `diff`=0, `bout`=1.
- a=0, b=0, bin=1 → `diff`=0xF, `bout`=1 (0 with saturation). Also a=0xF, b=0xF, bin=0 → `diff`=0, `bout`=0.
- `start` pulsed with a=1, b=1 two cycles into a 7-2 operation → result `diff`=5, `bout`=0, and no second `done`.
- `rst_n` asserted at bit 2 of an operation → all outputs 0 immediately. After release, no `done`; a new 5-5 request gives `diff`=0.
- Exhaustive: all a, b, bin for WIDTH=4 run back-to-back, each `start` issued in the `done` cycle. Every result matches the reference model, with exactly 5 cycles between `done` pulses.
